sdram_rom_readback: RTL and testbench

//  Reads back a ROM image already written into SDRAM by the download path, as

---
 rtl/sdram_rom_readback.sv | 118 +++++++++++
 tb/tb_sdram_rom_readback.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_rom_readback.sv
// Reads back a ROM image from SDRAM over the toggle req/ack port, accumulating
// a 16-bit byte checksum and word count, with a per-read timeout.
module sdram_rom_readback #(
  parameter int AW          = 23,
  parameter int LW          = 20,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 1023
) (
  input  logic          clk_sys,
  input  logic          reset_n,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic [LW-1:0] len_words,
  output logic          port_req,
  input  logic          port_ack,
  output logic [AW-1:0] port_a,
  output logic [1:0]    port_ds,
  output logic          port_we,
  input  logic [15:0]   port_q,
  output logic          busy,
  output logic          done,
  output logic [15:0]   sum,
  output logic [LW-1:0] words_read,
  output logic          err_timeout
);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, DRAIN, REQ, WAIT, ACC, FIN} state_t;
  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0] ack_sync;
  logic                   ack_s, ack_eq, tmo_hit, last_word;
  logic [AW-1:0]          addr;
  logic [LW-1:0]          len_lat;
  logic [15:0]            q_lat;
  logic [8:0]             byte_sum;
  logic [TW-1:0]          tmo_cnt;

  assign port_ds   = 2'b11;
  assign port_we   = 1'b0;
  assign ack_s     = ack_sync[SYNC_STAGES-1];
  assign ack_eq    = (ack_s == port_req);
  assign tmo_hit   = (tmo_cnt == TW'(TIMEOUT));
  assign last_word = ((words_read + LW'(1)) == len_lat);
  assign byte_sum  = {1'b0, q_lat[15:8]} + {1'b0, q_lat[7:0]};

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start) state_nxt = (len_words == '0) ? FIN : DRAIN;
      // A transfer left outstanding by a reset must complete before we reuse the port.
      DRAIN: if (ack_eq) state_nxt = REQ;
             else if (tmo_hit) state_nxt = FIN;
      REQ:   state_nxt = WAIT;
      WAIT:  if (ack_eq) state_nxt = ACC;
             else if (tmo_hit) state_nxt = FIN;
      ACC:   state_nxt = last_word ? FIN : REQ;
      FIN:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      ack_sync    <= '0;
      port_req    <= 1'b0;
      port_a      <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      sum         <= '0;
      words_read  <= '0;
      err_timeout <= 1'b0;
      addr        <= '0;
      len_lat     <= '0;
      q_lat       <= '0;
      tmo_cnt     <= '0;
    end else begin
      ack_sync[0] <= port_ack;
      for (int i = 1; i < SYNC_STAGES; i++) ack_sync[i] <= ack_sync[i-1];
      state <= state_nxt;
      busy  <= (state_nxt != IDLE);
      done  <= (state == FIN);
      case (state)
        IDLE: if (start) begin
          addr        <= base_addr;
          len_lat     <= len_words;
          sum         <= '0;
          words_read  <= '0;
          err_timeout <= 1'b0;
          tmo_cnt     <= '0;
        end
        DRAIN: begin
          tmo_cnt <= tmo_cnt + TW'(1);
          if (!ack_eq && tmo_hit) err_timeout <= 1'b1;
        end
        REQ: begin
          port_a   <= addr;
          port_req <= ~port_req;
          tmo_cnt  <= '0;
        end
        WAIT: begin
          if (ack_eq) q_lat <= port_q;
          else begin
            tmo_cnt <= tmo_cnt + TW'(1);
            if (tmo_hit) err_timeout <= 1'b1;
          end
        end
        ACC: begin
          sum        <= sum + {7'd0, byte_sum};
          words_read <= words_read + LW'(1);
          addr       <= addr + AW'(1);
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_sdram_rom_readback.sv
// Bench for sdram_rom_readback: table vectors, hand-written corner sequences,
// and randomized runs against an array-based responder and checksum model.
`timescale 1ns/1ps
module tb_sdram_rom_readback;
  localparam int AW = 23, LW = 20, TMO = 15;
  localparam int NOHOLD = 32'h7fffffff;

  logic          clk_sys = 0, clk_sd = 0, reset_n = 0, start = 0;
  logic [AW-1:0] base_addr = '0;
  logic [LW-1:0] len_words = '0;
  logic          port_req, port_we, busy, done, err_timeout;
  logic          port_ack = 0;
  logic [AW-1:0] port_a;
  logic [1:0]    port_ds;
  logic [15:0]   port_q = '0, sum;
  logic [LW-1:0] words_read;

  sdram_rom_readback #(.AW(AW), .LW(LW), .SYNC_STAGES(2), .TIMEOUT(TMO)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .start(start), .base_addr(base_addr),
    .len_words(len_words), .port_req(port_req), .port_ack(port_ack), .port_a(port_a),
    .port_ds(port_ds), .port_we(port_we), .port_q(port_q), .busy(busy), .done(done),
    .sum(sum), .words_read(words_read), .err_timeout(err_timeout));

  always #5   clk_sys = ~clk_sys;
  always #3.5 clk_sd  = ~clk_sd;

  // SDRAM responder on its own clock; requests at index >= hold_idx are held.
  logic [15:0]   mem [logic [AW-1:0]];
  logic [AW-1:0] req_log [$];
  int  req_cnt = 0, hold_idx = NOHOLD, lat_max = 3, ridx = 0, lat = 0;
  bit  pend = 0;
  logic [AW-1:0] raddr = '0;

  function automatic logic [15:0] mem_rd(logic [AW-1:0] a);
    return mem.exists(a) ? mem[a] : 16'hDEAD;
  endfunction

  always @(posedge clk_sd) begin
    if (pend) begin
      if (ridx < hold_idx) begin
        if (lat > 0) lat--;
        else begin
          port_q   <= mem_rd(raddr);
          port_ack <= ~port_ack;
          pend = 0;
        end
      end
    end else if (port_req != port_ack) begin
      pend = 1; ridx = req_cnt; req_cnt++;
      raddr = port_a; req_log.push_back(port_a);
      lat = $urandom_range(0, lat_max);
    end
  end

  int  tog = 0, ndone = 0;
  logic last_req = 0;
  always @(posedge clk_sys) begin
    #2;
    if (port_req !== last_req) tog++;
    last_req = port_req;
    if (done === 1'b1) ndone++;
  end

  int n_cmp = 0, n_bad = 0;
  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Reference checksum: plain sum of both bytes of every word, modulo 2^16.
  function automatic logic [15:0] model_sum(logic [AW-1:0] b, int l);
    logic [15:0] s = '0, w;
    for (int i = 0; i < l; i++) begin
      w = mem_rd(b + AW'(i));
      s = s + {8'h0, w[15:8]} + {8'h0, w[7:0]};
    end
    return s;
  endfunction

  function automatic int addr_errs(logic [AW-1:0] b, int l);
    int e = 0;
    if (req_log.size() != l) return -1;
    for (int i = 0; i < l; i++) if (req_log[i] !== b + AW'(i)) e++;
    return e;
  endfunction

  task automatic load(input logic [AW-1:0] b, input int l, input bit ramp, input logic [15:0] w);
    for (int i = 0; i < l; i++)
      mem[b + AW'(i)] = ramp ? {8'(2*i+2), 8'(2*i+1)} : w;
  endtask

  task automatic load_rand(input logic [AW-1:0] b, input int l);
    for (int i = 0; i < l; i++) mem[b + AW'(i)] = 16'($urandom);
  endtask

  task automatic start_pulse(input logic [AW-1:0] b, input int l);
    @(negedge clk_sys);
    base_addr = b; len_words = LW'(l); start = 1;
    @(negedge clk_sys);
    start = 0;
  endtask

  task automatic wait_done(input int d0, input int budget);
    for (int i = 0; i < budget && ndone == d0; i++) @(negedge clk_sys);
    repeat (4) @(negedge clk_sys);
  endtask

  task automatic run_check(input string nm, input logic [AW-1:0] b, input int l,
                           input logic [15:0] exp_sum);
    int d0, t0;
    d0 = ndone; t0 = tog; req_log.delete();
    start_pulse(b, l);
    wait_done(d0, 6000);
    chk({nm, "_done"}, ndone - d0, 1);
    chk({nm, "_sum"}, sum, exp_sum);
    chk({nm, "_words"}, words_read, l);
    chk({nm, "_err"}, err_timeout, 0);
    chk({nm, "_toggles"}, tog - t0, l);
    chk({nm, "_addr"}, addr_errs(b, l), 0);
  endtask

  typedef struct {
    logic [AW-1:0] base;
    int            len;
    bit            ramp;
    logic [15:0]   word;
    logic [15:0]   exp_sum;
  } vec_t;
  vec_t vt[4];

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, t0;
    logic [AW-1:0] b;
    int l;

    vt[0] = '{23'h013100, 4,   1'b1, 16'h0000, 16'h0024};
    vt[1] = '{23'h7FFFFE, 3,   1'b0, 16'hFFFF, 16'((3 * 510) % 65536)};
    vt[2] = '{23'h000100, 300, 1'b0, 16'hFFFF, 16'((300 * 510) % 65536)};
    vt[3] = '{23'h000500, 0,   1'b0, 16'h1234, 16'h0000};

    repeat (3) @(negedge clk_sys);
    chk("rst_busy", busy, 0);   chk("rst_done", done, 0);
    chk("rst_req", port_req, 0); chk("rst_a", port_a, 0);
    chk("rst_sum", sum, 0);     chk("rst_words", words_read, 0);
    chk("rst_err", err_timeout, 0);
    chk("ds_const", port_ds, 2'b11); chk("we_const", port_we, 0);
    reset_n = 1;
    repeat (3) @(negedge clk_sys);

    foreach (vt[i]) begin
      load(vt[i].base, vt[i].len, vt[i].ramp, vt[i].word);
      run_check($sformatf("vec%0d", i), vt[i].base, vt[i].len, vt[i].exp_sum);
      if (i == 1) chk("wrap_last_a", req_log.size() == 3 ? req_log[2] : 23'h1, 0);
    end

    // Zero length: busy for one cycle, done the cycle after, no port traffic.
    d0 = ndone; t0 = tog;
    @(negedge clk_sys); base_addr = 23'h40; len_words = '0; start = 1;
    @(negedge clk_sys); start = 0;
    chk("len0_busy", busy, 1); chk("len0_done_early", done, 0);
    @(negedge clk_sys);
    chk("len0_done", done, 1); chk("len0_busy_off", busy, 0);
    @(negedge clk_sys);
    chk("len0_done_pulse", done, 0);
    chk("len0_toggles", tog - t0, 0); chk("len0_sum", sum, 0);

    // Second word never acknowledged: timeout, one word counted.
    load(23'h800, 4, 1'b1, 16'h0);
    hold_idx = req_cnt + 1;
    d0 = ndone; t0 = tog; req_log.delete();
    start_pulse(23'h800, 4);
    wait_done(d0, 300);
    chk("tmo_done", ndone - d0, 1);
    chk("tmo_err", err_timeout, 1);
    chk("tmo_words", words_read, 1);
    chk("tmo_toggles", tog - t0, 2);
    chk("tmo_sum", sum, model_sum(23'h800, 1));
    repeat (5) @(negedge clk_sys);
    chk("tmo_sticky", err_timeout, 1);
    hold_idx = NOHOLD;
    repeat (10) @(negedge clk_sys);

    // Reset while a read is outstanding with port_req low; the late ack must be drained.
    lat_max = 1;
    load_rand(23'h200, 4);
    load_rand(23'h4440, 5);
    hold_idx = req_cnt + (port_req ? 0 : 1);
    start_pulse(23'h200, 4);
    for (int i = 0; i < 200 && req_cnt <= hold_idx; i++) @(negedge clk_sys);
    chk("rr_held_seen", req_cnt > hold_idx, 1);
    repeat (2) @(negedge clk_sys);
    reset_n = 0;
    @(negedge clk_sys);
    chk("rr_busy", busy, 0); chk("rr_req", port_req, 0); chk("rr_sum", sum, 0);
    chk("rr_words", words_read, 0); chk("rr_a", port_a, 0);
    reset_n = 1;
    repeat (4) @(negedge clk_sys);
    d0 = ndone; t0 = tog; req_log.delete();
    start_pulse(23'h4440, 5);
    repeat (4) @(negedge clk_sys);
    chk("rr_drain_busy", busy, 1);
    chk("rr_drain_hold", tog - t0, 0);
    hold_idx = NOHOLD;
    wait_done(d0, 500);
    chk("rr_done", ndone - d0, 1);
    chk("rr_err", err_timeout, 0);
    chk("rr_words_after", words_read, 5);
    chk("rr_sum_after", sum, model_sum(23'h4440, 5));
    chk("rr_addr", addr_errs(23'h4440, 5), 0);
    lat_max = 3;

    // Start while busy is ignored.
    load_rand(23'h2000, 4);
    d0 = ndone; req_log.delete();
    start_pulse(23'h2000, 4);
    start_pulse(23'h3000, 7);
    wait_done(d0, 500);
    chk("busy_start_done", ndone - d0, 1);
    chk("busy_start_words", words_read, 4);
    chk("busy_start_addr", addr_errs(23'h2000, 4), 0);
    chk("busy_start_sum", sum, model_sum(23'h2000, 4));

    // Start held high into the FIN cycle of a zero-length run is ignored.
    d0 = ndone; t0 = tog;
    @(negedge clk_sys); base_addr = 23'h10; len_words = '0; start = 1;
    @(negedge clk_sys); base_addr = 23'h5555; len_words = LW'(5);
    @(negedge clk_sys); start = 0;
    chk("fin_start_done", done, 1);
    repeat (6) @(negedge clk_sys);
    chk("fin_start_busy", busy, 0);
    chk("fin_start_toggles", tog - t0, 0);
    chk("fin_start_ndone", ndone - d0, 1);

    // Randomized runs.
    for (int r = 0; r < 8; r++) begin
      b = AW'($urandom);
      l = $urandom_range(1, 24);
      lat_max = $urandom_range(0, 3);
      load_rand(b, l);
      run_check($sformatf("rnd%0d", r), b, l, model_sum(b, l));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
